// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer draw blocks: screen geometry,
// the fill FSM state encoding and a coordinate clamp helper.
package fb_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    INIT,
    DRAW,
    DONE
  } fb_state_e;

  // Limit a signed coordinate to the inclusive range [lo, hi].
  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) begin
      return lo;
    end
    if (v > hi) begin
      return hi;
    end
    return v;
  endfunction

endpackage

// File: rtl/fb_rect_fill.sv
// Solid rectangle fill into a linear framebuffer. A request is latched on
// start, held until the next frame pulse, then the clipped rectangle is
// written one pixel per cycle in raster order using incremental addressing.
module fb_rect_fill #(
  parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT,
  parameter int CORDW     = 16,
  parameter int CIDXW     = 4,
  parameter int FB_ADDRW  = $clog2(FB_WIDTH*FB_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    frame,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  input  logic [CIDXW-1:0]        colr,
  output logic                    we,
  output logic [FB_ADDRW-1:0]     addr_write,
  output logic [CIDXW-1:0]        data_out,
  output logic                    busy,
  output logic                    done
);
  import fb_pkg::*;

  fb_state_e state_q;

  logic signed [CORDW-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [CIDXW-1:0]        colr_q;

  logic [CORDW-1:0]    xStart_q, xEnd_q, yEnd_q;
  logic [CORDW-1:0]    x_q, y_q;
  logic [FB_ADDRW-1:0] rowStart_q, addr_q;
  logic [CIDXW-1:0]    data_q;
  logic                we_q, busy_q, done_q;

  logic signed [CORDW-1:0] xLo, xHi, yLo, yHi;
  logic                    offScreen;
  logic [CORDW-1:0]        xStart_d, xEnd_d, yStart_d, yEnd_d;
  logic [FB_ADDRW-1:0]     rowStart_d;

  // Order the latched corners, detect a fully off-screen rectangle and clip
  // it; the only multiply turns the first clipped row into a base address.
  always_comb begin
    xLo = (x0_q > x1_q) ? x1_q : x0_q;
    xHi = (x0_q > x1_q) ? x0_q : x1_q;
    yLo = (y0_q > y1_q) ? y1_q : y0_q;
    yHi = (y0_q > y1_q) ? y0_q : y1_q;

    offScreen = (int'(xHi) < 0) || (int'(xLo) > FB_WIDTH - 1) ||
                (int'(yHi) < 0) || (int'(yLo) > FB_HEIGHT - 1);

    xStart_d = CORDW'(clamp(int'(xLo), 0, FB_WIDTH - 1));
    xEnd_d   = CORDW'(clamp(int'(xHi), 0, FB_WIDTH - 1));
    yStart_d = CORDW'(clamp(int'(yLo), 0, FB_HEIGHT - 1));
    yEnd_d   = CORDW'(clamp(int'(yHi), 0, FB_HEIGHT - 1));

    rowStart_d = FB_ADDRW'(int'(yStart_d) * FB_WIDTH);
  end

  // Request sequencing, pixel counters and registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      colr_q     <= '0;
      xStart_q   <= '0;
      xEnd_q     <= '0;
      yEnd_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      rowStart_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            x0_q    <= x0;
            y0_q    <= y0;
            x1_q    <= x1;
            y1_q    <= y1;
            colr_q  <= colr;
            busy_q  <= 1'b1;
            state_q <= WAIT_FRAME;
          end
        end

        WAIT_FRAME: begin
          if (frame) begin
            state_q <= INIT;
          end
        end

        INIT: begin
          data_q <= colr_q;
          if (offScreen) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            xStart_q   <= xStart_d;
            xEnd_q     <= xEnd_d;
            yEnd_q     <= yEnd_d;
            x_q        <= xStart_d;
            y_q        <= yStart_d;
            rowStart_q <= rowStart_d;
            addr_q     <= rowStart_d + FB_ADDRW'(xStart_d);
            we_q       <= 1'b1;
            state_q    <= DRAW;
          end
        end

        DRAW: begin
          if (x_q == xEnd_q) begin
            if (y_q == yEnd_q) begin
              we_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              x_q        <= xStart_q;
              y_q        <= y_q + CORDW'(1);
              rowStart_q <= rowStart_q + FB_ADDRW'(FB_WIDTH);
              addr_q     <= rowStart_q + FB_ADDRW'(FB_WIDTH) + FB_ADDRW'(xStart_q);
            end
          end else begin
            x_q    <= x_q + CORDW'(1);
            addr_q <= addr_q + FB_ADDRW'(1);
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign we         = we_q;
  assign addr_write = addr_q;
  assign data_out   = data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: directed table of rectangles, random
// rectangles against a pixel-list reference model, and hand-written
// sequences for start/frame overlap, start during completion and reset.
module tb_fb_rect_fill;

  localparam int W = 160;
  localparam int H = 120;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               frame;
  logic signed [15:0] x0, y0, x1, y1;
  logic [3:0]         colr;
  logic               we;
  logic [14:0]        addr_write;
  logic [3:0]         data_out;
  logic               busy;
  logic               done;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  int wrAddr[$];
  int wrData[$];
  int wrCyc[$];
  int expAddr[$];
  int doneCount = 0;
  int doneCyc   = 0;
  logic doneBusy = 1'b0;

  typedef struct {
    int    x0, y0, x1, y1;
    int    c;
    int    expCount;
    int    expFirst;
    int    expLast;
    bit    mid;
    string name;
  } vec_t;

  vec_t vecs[5];

  fb_rect_fill dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame      (frame),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .colr       (colr),
    .we         (we),
    .addr_write (addr_write),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write and every completion pulse, stamped with the cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (we) begin
        wrAddr.push_back(int'(addr_write));
        wrData.push_back(int'(data_out));
        wrCyc.push_back(cyc);
      end
      if (done) begin
        doneCount = doneCount + 1;
        doneCyc   = cyc;
        doneBusy  = busy;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clearCapture();
    wrAddr.delete();
    wrData.delete();
    wrCyc.delete();
    doneCount = 0;
  endtask

  // Single-cycle start with the given rectangle, then scramble the inputs.
  task automatic applyStimulus(input int ax0, input int ay0, input int ax1, input int ay1, input int c);
    x0    = 16'(ax0);
    y0    = 16'(ay0);
    x1    = 16'(ax1);
    y1    = 16'(ay1);
    colr  = 4'(c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x0    = 16'($urandom);
    y0    = 16'($urandom);
    x1    = 16'($urandom);
    y1    = 16'($urandom);
    colr  = 4'($urandom);
  endtask

  task automatic pulseFrame(output int fc);
    fc    = cyc;
    frame = 1'b1;
    @(posedge clk); #1;
    frame = 1'b0;
  endtask

  // Reference: the list of pixel addresses the rectangle covers on screen.
  function automatic void buildModel(input int ax0, input int ay0, input int ax1, input int ay1);
    int xl, xh, yl, yh;
    expAddr.delete();
    xl = (ax0 < ax1) ? ax0 : ax1;
    xh = (ax0 < ax1) ? ax1 : ax0;
    yl = (ay0 < ay1) ? ay0 : ay1;
    yh = (ay0 < ay1) ? ay1 : ay0;
    if (xh < 0 || xl > W - 1 || yh < 0 || yl > H - 1) return;
    if (xl < 0) xl = 0;
    if (yl < 0) yl = 0;
    if (xh > W - 1) xh = W - 1;
    if (yh > H - 1) yh = H - 1;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++)
        expAddr.push_back(y * W + x);
  endfunction

  task automatic runFill(input int ax0, input int ay0, input int ax1, input int ay1,
                         input int c, input string name, input bit midStart);
    int  frameCyc;
    int  n;
    bit  issued;
    int  failsBefore;
    issued = 1'b0;
    @(posedge clk); #1;
    applyStimulus(ax0, ay0, ax1, ay1, c);
    checkOutput({name, " busy after start"}, 32'(busy), 1);
    clearCapture();
    @(posedge clk); #1;
    checkOutput({name, " writes before frame"}, wrAddr.size(), 0);
    pulseFrame(frameCyc);
    for (int i = 0; i < W * H + 100 && doneCount == 0; i++) begin
      if (midStart && !issued && wrAddr.size() >= 1000) begin
        x0 = 0; y0 = 0; x1 = 3; y1 = 3; colr = 4'hF;
        start  = 1'b1;
        issued = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    checkOutput({name, " done seen"}, 32'(doneCount > 0), 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, " done pulses"}, doneCount, 1);
    checkOutput({name, " busy in done"}, 32'(doneBusy), 0);
    checkOutput({name, " busy after"}, 32'(busy), 0);

    buildModel(ax0, ay0, ax1, ay1);
    checkOutput({name, " write count"}, wrAddr.size(), expAddr.size());
    n = (wrAddr.size() < expAddr.size()) ? wrAddr.size() : expAddr.size();
    for (int i = 0; i < n; i++) begin
      failsBefore = failCount;
      checkOutput({name, " addr"}, wrAddr[i], expAddr[i]);
      checkOutput({name, " data"}, wrData[i], c);
      if (failCount != failsBefore) break;
    end
    if (wrAddr.size() > 0) begin
      checkOutput({name, " first write cycle"}, wrCyc[0], frameCyc + 2);
      checkOutput({name, " contiguous"}, wrCyc[wrCyc.size()-1] - wrCyc[0], wrCyc.size() - 1);
      checkOutput({name, " done cycle"}, doneCyc, wrCyc[wrCyc.size()-1] + 1);
    end else begin
      checkOutput({name, " done cycle"}, doneCyc, frameCyc + 2);
    end
  endtask

  initial begin
    int fc;
    bit seen;
    int rx0, ry0, rx1, ry1;

    vecs[0] = '{x0:10,  y0:20, x1:13,  y1:21,  c:5, expCount:8,     expFirst:3210, expLast:3373,  mid:1'b0, name:"basic"};
    vecs[1] = '{x0:13,  y0:21, x1:10,  y1:20,  c:5, expCount:8,     expFirst:3210, expLast:3373,  mid:1'b0, name:"reversed"};
    vecs[2] = '{x0:-5,  y0:-5, x1:2,   y1:1,   c:9, expCount:6,     expFirst:0,    expLast:162,   mid:1'b0, name:"clip"};
    vecs[3] = '{x0:200, y0:5,  x1:250, y1:9,   c:2, expCount:0,     expFirst:0,    expLast:0,     mid:1'b0, name:"offscreen"};
    vecs[4] = '{x0:0,   y0:0,  x1:159, y1:119, c:6, expCount:19200, expFirst:0,    expLast:19199, mid:1'b1, name:"fullscreen"};

    rst = 1'b1; start = 1'b0; frame = 1'b0;
    x0 = 0; y0 = 0; x1 = 0; y1 = 0; colr = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset we",   32'(we), 0);
    checkOutput("reset addr", 32'(addr_write), 0);
    checkOutput("reset data", 32'(data_out), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset done", 32'(done), 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      runFill(vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1, vecs[v].c, vecs[v].name, vecs[v].mid);
      checkOutput({vecs[v].name, " table count"}, wrAddr.size(), vecs[v].expCount);
      if (vecs[v].expCount > 0 && wrAddr.size() > 0) begin
        checkOutput({vecs[v].name, " table first"}, wrAddr[0], vecs[v].expFirst);
        checkOutput({vecs[v].name, " table last"}, wrAddr[wrAddr.size()-1], vecs[v].expLast);
      end
    end

    for (int r = 0; r < 16; r++) begin
      rx0 = int'($urandom_range(0, 239)) - 40;
      ry0 = int'($urandom_range(0, 179)) - 30;
      rx1 = rx0 + int'($urandom_range(0, 40)) - 20;
      ry1 = ry0 + int'($urandom_range(0, 40)) - 20;
      runFill(rx0, ry0, rx1, ry1, int'($urandom_range(0, 15)), "random", 1'b0);
    end

    // Frame arriving together with start must not begin the fill.
    @(posedge clk); #1;
    x0 = 1; y0 = 1; x1 = 2; y1 = 2; colr = 4'd3;
    start = 1'b1; frame = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; frame = 1'b0;
    clearCapture();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("coincident no writes", wrAddr.size(), 0);
    checkOutput("coincident still busy", 32'(busy), 1);
    pulseFrame(fc);
    for (int i = 0; i < 100 && doneCount == 0; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("coincident done seen", 32'(doneCount), 1);
    checkOutput("coincident count", wrAddr.size(), 4);
    if (wrAddr.size() == 4) begin
      checkOutput("coincident first", wrAddr[0], 161);
      checkOutput("coincident last", wrAddr[3], 322);
    end

    // Start presented during the completion cycle must be dropped.
    @(posedge clk); #1;
    applyStimulus(0, 0, 1, 0, 7);
    clearCapture();
    pulseFrame(fc);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk); #1;
      if (done) begin
        x0 = 0; y0 = 0; x1 = 5; y1 = 5; colr = 4'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b1;
      end
    end
    checkOutput("done-start done seen", 32'(seen), 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done-start busy", 32'(busy), 0);
    clearCapture();
    pulseFrame(fc);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("done-start no writes", wrAddr.size(), 0);
    checkOutput("done-start no done", doneCount, 0);

    // Reset in the middle of a full-screen fill.
    @(posedge clk); #1;
    applyStimulus(0, 0, 159, 119, 3);
    clearCapture();
    pulseFrame(fc);
    for (int i = 0; i < 200 && wrAddr.size() < 50; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("midreset reached 50", 32'(wrAddr.size() >= 50), 1);
    rst = 1'b1;
    #1;
    checkOutput("midreset we", 32'(we), 0);
    checkOutput("midreset busy", 32'(busy), 0);
    checkOutput("midreset done", 32'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clearCapture();
    repeat (20) @(posedge clk);
    #1;
    checkOutput("midreset no writes", wrAddr.size(), 0);
    checkOutput("midreset no done", doneCount, 0);
    checkOutput("midreset idle busy", 32'(busy), 0);
    runFill(10, 20, 13, 21, 5, "after reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
